// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//
// Architectural register file for the single-cycle RISC-V datapath.
// 32 architectural registers of N bits; x0 is hardwired to zero and has no
// storage. One synchronous write port, two independent combinational read
// ports.
//
// Parameters:
//   N          register width in bits (default 32)
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous active-high reset, clears x1..x31
//   wr_ena     write enable
//   wr_addr    destination register index (rd)
//   wr_data    value to write
//   rd_addr0   read port 0 index (rs1)
//   rd_data0   read port 0 data
//   rd_addr1   read port 1 index (rs2)
//   rd_data1   read port 1 data
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a write in flight is forwarded to any
//                      read port addressing the same (non-zero) register in
//                      the same cycle. Suppressed while rst is high. Storage
//                      and write behaviour are identical in both builds.
// ---------------------------------------------------------------------------
module register_file #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_ena,
    input  logic [4:0]   wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic [4:0]   rd_addr0,
    output logic [N-1:0] rd_data0,
    input  logic [4:0]   rd_addr1,
    output logic [N-1:0] rd_data1
);

    // -----------------------------------------------------------------------
    // Write decode: 5-to-32 one-hot gated by wr_ena. Bit 0 is forced low so
    // a write to x0 never reaches any storage.
    // -----------------------------------------------------------------------
    logic [31:0] wr_sel;

    always_comb begin
        // NOTE: every combinational output gets a default first; without it
        // the paths that do not assign it would infer a latch.
        wr_sel = '0;
        if (wr_ena) begin
            wr_sel[wr_addr] = 1'b1;
        end
        wr_sel[0] = 1'b0;
    end

    // -----------------------------------------------------------------------
    // Storage for x1..x31 only.
    // -----------------------------------------------------------------------
    logic [N-1:0] regs [1:31];

    always_ff @(posedge clk) begin
        // NOTE: this array is reset on purpose: reads must be defined right
        // after the first reset edge, so it cannot map to a reset-less RAM.
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                // NOTE: sequential state uses non-blocking assignment so all
                // registers update together from pre-edge values.
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wr_sel[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Flat 32-entry read view with a constant zero in slot 0, so both read
    // ports are plain 32:1 selects indexed directly by the 5-bit address.
    // -----------------------------------------------------------------------
    logic [N-1:0] view [32];

    assign view[0] = '0;

    for (genvar g = 1; g < 32; g++) begin : g_view
        assign view[g] = regs[g];
    end

`ifdef REGFILE_BYPASS_EN
    // A write qualifies for forwarding only when it will really land in
    // storage at the next edge: enabled, not x0, and not killed by reset.
    logic fwd_ok;
    assign fwd_ok = wr_ena && !rst && (wr_addr != 5'd0);
`endif

    // -----------------------------------------------------------------------
    // Read port 0
    // -----------------------------------------------------------------------
    always_comb begin
        rd_data0 = view[rd_addr0];
`ifdef REGFILE_BYPASS_EN
        if (fwd_ok && (rd_addr0 == wr_addr)) begin
            rd_data0 = wr_data;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Read port 1
    // -----------------------------------------------------------------------
    always_comb begin
        rd_data1 = view[rd_addr1];
`ifdef REGFILE_BYPASS_EN
        if (fwd_ok && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_data;
        end
`endif
    end

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
//
// Self-checking bench for register_file (N = 32). A behavioural model of the
// architectural registers is updated on every rising edge; a compare process
// checks both read ports against it on every falling edge once reset has been
// applied. Directed steps add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_register_file;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic         wr_ena;
    logic [4:0]   wr_addr;
    logic [N-1:0] wr_data;
    logic [4:0]   rd_addr0;
    logic [N-1:0] rd_data0;
    logic [4:0]   rd_addr1;
    logic [N-1:0] rd_data1;

    int tests = 0;
    int fails = 0;

    register_file #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_ena   (wr_ena),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr0 (rd_addr0),
        .rd_data0 (rd_data0),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act,
                         input logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Model: architectural register contents, x0 always zero.
    // -----------------------------------------------------------------------
    logic [N-1:0] mdl [32];
    bit           mdl_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = '0;
            mdl_valid = 1'b1;
        end else if (wr_ena && wr_addr != 5'd0) begin
            mdl[wr_addr] = wr_data;
        end
    end

    function automatic logic [N-1:0] expect_read(input logic [4:0] addr);
        if (addr == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_ena && !rst && wr_addr == addr) return wr_data;
`endif
        return mdl[addr];
    endfunction

    always @(negedge clk) begin
        if (mdl_valid) begin
            check("model_port0", rd_data0, expect_read(rd_addr0));
            check("model_port1", rd_data1, expect_read(rd_addr1));
        end
    end

    // Drive one cycle's worth of inputs just after the rising edge.
    task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                         input logic [N-1:0] wd, input logic [4:0] ra0,
                         input logic [4:0] ra1);
        @(posedge clk);
        #1;
        rst = r; wr_ena = we; wr_addr = wa; wr_data = wd;
        rd_addr0 = ra0; rd_addr1 = ra1;
    endtask

    logic [N-1:0] pat;

    initial begin
        rst = 1'b1; wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr0 = '0; rd_addr1 = '0;
        // Garbage write during reset must be dropped.
        drive(1, 1, 5'd2, 32'hBAD0BAD0, 5'd0, 5'd0);
        drive(1, 0, 5'd0, 32'h0, 5'd0, 5'd0);

        // Reset state: every address reads zero on both ports.
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            @(negedge clk);
            check("reset_p0", rd_data0, 32'h0);
            check("reset_p1", rd_data1, 32'h0);
        end

        // Write x5, read it on both ports next cycle, neighbours untouched.
        drive(0, 1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        drive(0, 0, 5'd0, 32'h0, 5'd5, 5'd5);
        @(negedge clk);
        check("x5_p0", rd_data0, 32'hDEADBEEF);
        check("x5_p1", rd_data1, 32'hDEADBEEF);
        drive(0, 0, 5'd0, 32'h0, 5'd4, 5'd6);
        @(negedge clk);
        check("x4_zero", rd_data0, 32'h0);
        check("x6_zero", rd_data1, 32'h0);

        // Write to x0 is discarded.
        drive(0, 1, 5'd0, 32'h12345678, 5'd0, 5'd0);
        drive(0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        check("x0_p0", rd_data0, 32'h0);
        check("x0_p1", rd_data1, 32'h0);

        // wr_ena=0 leaves x7 unchanged.
        drive(0, 1, 5'd7, 32'h00000707, 5'd0, 5'd0);
        drive(0, 0, 5'd7, 32'hFFFFFFFF, 5'd7, 5'd0);
        drive(0, 0, 5'd0, 32'h0, 5'd7, 5'd7);
        @(negedge clk);
        check("x7_hold", rd_data0, 32'h00000707);

        // Same-cycle read of the register being written.
        drive(0, 1, 5'd9, 32'h00000001, 5'd0, 5'd0);
        drive(0, 1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd0);
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        check("x9_same_cycle", rd_data0, 32'hA5A5A5A5);
`else
        check("x9_same_cycle", rd_data0, 32'h00000001);
`endif
        check("x9_port1_x0", rd_data1, 32'h0);
        drive(0, 0, 5'd0, 32'h0, 5'd9, 5'd9);
        @(negedge clk);
        check("x9_after", rd_data0, 32'hA5A5A5A5);

        // Fill x1..x31 with index*0x01010101 and sweep ports in opposite
        // directions.
        for (int i = 1; i < 32; i++) begin
            drive(0, 1, 5'(i), 32'h01010101 * 32'(i), 5'd0, 5'd0);
        end
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            @(negedge clk);
            pat = 32'h01010101 * 32'(i);
            check("sweep_p0", rd_data0, pat);
            pat = 32'h01010101 * 32'(31 - i);
            check("sweep_p1", rd_data1, pat);
        end
        drive(0, 0, 5'd0, 32'h0, 5'd31, 5'd16);
        @(negedge clk);
        check("x31_literal", rd_data0, 32'h1F1F1F1F);
        check("x16_literal", rd_data1, 32'h10101010);

        // Reset has priority over a simultaneous write.
        drive(0, 1, 5'd3, 32'h00000055, 5'd0, 5'd0);
        drive(1, 1, 5'd3, 32'h00000077, 5'd3, 5'd3);
        @(negedge clk);
        check("x3_before_rst", rd_data0, 32'h00000055);
        drive(0, 0, 5'd0, 32'h0, 5'd3, 5'd5);
        @(negedge clk);
        check("x3_after_rst", rd_data0, 32'h0);
        check("x5_after_rst", rd_data1, 32'h0);
        drive(0, 1, 5'd3, 32'h00000077, 5'd3, 5'd0);
        drive(0, 0, 5'd0, 32'h0, 5'd3, 5'd3);
        @(negedge clk);
        check("x3_rewrite", rd_data0, 32'h00000077);
        check("x3_rewrite_p1", rd_data1, 32'h00000077);

        // Back-to-back writes to one register: last edge wins.
        drive(0, 1, 5'd12, 32'h11111111, 5'd0, 5'd0);
        drive(0, 1, 5'd12, 32'h22222222, 5'd0, 5'd0);
        drive(0, 0, 5'd0, 32'h0, 5'd12, 5'd0);
        @(negedge clk);
        check("x12_last_wins", rd_data0, 32'h22222222);

        drive(0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
